axil_spi_master: RTL and testbench
==================================

# axil_spi_master

AXI4-Lite slave to SPI master bridge. A parametrised successor to the fixed 32-bit, 8-select bridge, adding:
- programmable transfer length (1..MAX_BITS);
- all four CPOL/CPHA modes and MSB/LSB-first shifting;
- a programmable SCLK divider and a per-transfer slave-select mask;
- sticky status flags with error responses.

It sits between the system AXI4-Lite interconnect and off-chip SPI peripherals.

## Interface
Parameters:
- ADDR_W, 8, AXI address width; only bits [4:2] decode, other bits ignored.
- MAX_BITS, 32, maximum bits per transfer; sets the TXDATA/RXDATA width; 1 ≤ MAX_BITS ≤ 32.
- NUM_SS, 8, number of slave-select outputs; 1 ≤ NUM_SS ≤ 32.
- DIV_W, 8, width of the SCLK divider field.

Ports:
- ACLK  in  1  single clock; all logic on the rising edge.
- ARESET  in  1  synchronous reset, active-high.
- AWADDR  in  ADDR_W; AWVALID in 1; AWREADY out 1  write address channel.
- WDATA  in  32; WSTRB in 4; WVALID in 1; WREADY out 1  write data channel.
- BRESP  out  2; BVALID out 1; BREADY in 1  write response channel.
- ARADDR  in  ADDR_W; ARVALID in 1; ARREADY out 1  read address channel.
- RDATA  out  32; RRESP out 2; RVALID out 1; RREADY in 1  read data channel.
- SCLK  out  1  SPI clock; idles at CPOL.
- MOSI  out  1  SPI data out.
- MISO  in  1  SPI data in.
- SS  out  NUM_SS  active-low slave selects; all ones when idle.

## Operation
Register map (byte offsets):
- 0x00 CTRL (R/W)
  - [0] CPOL, [1] CPHA, [2] LSB_FIRST.
  - [13:8] LEN-1; values ≥ MAX_BITS saturate to MAX_BITS-1.
  - [16+DIV_W-1:16] DIV.
- 0x04 STATUS (R, W1C)
  - [0] BUSY (read-only).
  - [1] DONE: sticky; set at transfer end; cleared by an RXDATA read or W1C.
  - [2] OVR: sticky; set by a TXDATA write while BUSY; cleared by W1C.
- 0x08 TXDATA (W): when idle, loads the shifter and starts a transfer. When BUSY the write is dropped, OVR sets and BRESP=SLVERR.
- 0x0C RXDATA (R): last received word, right-aligned; bits above LEN read 0.
- 0x10 SSMASK (R/W) [NUM_SS-1:0]: during a transfer SS = ~SSMASK. Reset value 1.
- Unmapped offsets: writes are ignored with SLVERR; reads return 0 with SLVERR. RRESP and BRESP are OKAY otherwise.
- WSTRB is honoured per byte on CTRL, SSMASK and TXDATA. A TXDATA write with WSTRB=0 does not start a transfer.
- CTRL, SSMASK and DIV are latched at transfer start; writes while BUSY affect the next transfer only.

AXI write path:
- AW and W are accepted independently, each into a one-entry holding register. AWREADY/WREADY are high while that register is empty and BVALID is low.
- The write executes in the cycle after both registers are full. BVALID rises the same cycle and holds until BREADY.

AXI read path:
- ARREADY = !RVALID.
- RVALID rises one cycle after the AR handshake and holds, with RDATA/RRESP stable, until RREADY.

SPI FSM: IDLE → LEAD → SHIFT → TRAIL → IDLE.
- IDLE: SS all ones, SCLK=CPOL. On a valid TXDATA write go to LEAD and set BUSY.
- LEAD: SS asserted for one half-period (DIV+1 ACLK cycles). MOSI presents the first bit when CPHA=0.
- SHIFT: SCLK toggles every DIV+1 cycles for 2·LEN edges.
  - CPHA=0: sample MISO on leading edges, shift MOSI on trailing edges.
  - CPHA=1: shift MOSI on leading edges, sample on trailing edges.
- TRAIL: one half-period with SCLK=CPOL and SS still asserted. Then: SS deasserts, RXDATA updates, DONE=1, BUSY=0, return to IDLE.

## Timing
- Reset values:
  - AWREADY, WREADY, ARREADY, BVALID and RVALID are 0. Ready signals go high on the first cycle after reset.
  - BRESP/RRESP/RDATA 0, SCLK 0, MOSI 0, SS all ones.
  - CTRL 0, SSMASK 1, STATUS 0, RXDATA 0.
- Transfer duration from the B-handshake-producing cycle to BUSY=0 is (2·LEN+2)·(DIV+1) ACLK cycles. BUSY reads 1 from the cycle after the write executes.
- SCLK period is 2·(DIV+1) ACLK cycles. DIV=0 gives ACLK/2.
- Transfer completion and an RXDATA read in the same cycle: the read returns the old RXDATA, and DONE stays set.
- W1C of DONE in the same cycle as completion: DONE ends set.
- Reset mid-transfer:
  - The next cycle has SS all ones, SCLK 0 and FSM IDLE.
  - Any outstanding AXI response is discarded.

## Test plan
- Mode 0 loopback: CTRL=0x0001_0700 (LEN 8, DIV 1), SSMASK=0x01, TXDATA=0xA5, MISO tied to MOSI. Required:
  - SS[0] low, other SS high;
  - 8 SCLK pulses, period 4 cycles;
  - MOSI sequence 1,0,1,0,0,1,0,1;
  - RXDATA=0x0000_00A5 and DONE=1.
- Mode 3 LSB-first 32-bit: CTRL=0x0000_1F07, SSMASK=0x80, TXDATA=0xAAAA_AAAA. Required:
  - SCLK idles high;
  - MOSI bit order LSB first;
  - SS[7] low for 66 cycles;
  - RXDATA equals the MISO stream captured by the bench.
- Overrun: TXDATA write during BUSY → BRESP=SLVERR, OVR=1, and the transfer in flight completes unchanged. Writing STATUS 0x4 clears OVR.
- Handshake ordering and backpressure:
  - W before AW, AW before W, and both together: each gives exactly one B response.
  - BREADY low for 3 cycles: BVALID holds and no new AW/W is accepted.
  - RREADY low: RDATA stays stable.
- Unmapped access: read from 0x1C → RDATA=0, RRESP=SLVERR. Write to 0x18 → BRESP=SLVERR and no register changes.
- Reset during SHIFT: assert ARESET mid-transfer → the next cycle has SS=0xFF, SCLK=0, STATUS=0, CTRL=0.

Source files
------------

// File: rtl/axil_spi_master.sv
// AXI4-Lite slave bridging to a single SPI master channel: programmable length,
// CPOL/CPHA, bit order, SCLK divider and per-transfer slave-select mask.
module axil_spi_master #(
  parameter int ADDR_W   = 8,
  parameter int MAX_BITS = 32,
  parameter int NUM_SS   = 8,
  parameter int DIV_W    = 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_SS-1:0] SS
);
  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL} state_t;
  state_t r_state, w_next;

  logic              r_aw_full, r_w_full, r_bvalid, r_rvalid, r_done, r_ovr;
  logic [2:0]        r_aw_sel;
  logic [31:0]       r_wdata, r_rdata, r_ctrl;
  logic [3:0]        r_wstrb;
  logic [1:0]        r_bresp, r_rresp;
  logic [NUM_SS-1:0] r_ssmask, r_ss;
  logic [MAX_BITS-1:0] r_txdata, r_rxdata, r_tx_sh, r_rx_sh;
  logic              r_cpha, r_lsb, r_sclk, r_mosi;
  logic [5:0]        r_len_m1;
  logic [DIV_W-1:0]  r_div, r_cnt;
  logic [6:0]        r_edge;

  logic [31:0] w_wmask, w_ctrl_m, w_ctrl_new, w_tx_m32, w_ss_m32, w_rd_data;
  logic [1:0]  w_rd_resp, w_wr_resp;
  logic [MAX_BITS-1:0] w_tx_merge, w_tx_al, w_tx_al_sh, w_sh_next, w_rx_next;
  logic w_busy, w_wr_exec, w_rd_hs, w_tx_start, w_tx_ovr, w_done_clr, w_ovr_clr;
  logic w_tick, w_last_edge, w_xfer_end, w_do_sample, w_head, w_first;
  logic w_unused;

  assign w_busy    = (r_state != S_IDLE);
  assign w_wr_exec = r_aw_full & r_w_full & ~r_bvalid;
  assign w_rd_hs   = ARVALID & ARREADY;
  assign w_wmask   = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
  assign w_ctrl_m  = (r_ctrl & ~w_wmask) | (r_wdata & w_wmask);
  assign w_tx_m32  = (32'(r_txdata) & ~w_wmask) | (r_wdata & w_wmask);
  assign w_ss_m32  = (32'(r_ssmask) & ~w_wmask) | (r_wdata & w_wmask);
  assign w_tx_merge = w_tx_m32[MAX_BITS-1:0];

  assign w_tx_start = w_wr_exec && (r_aw_sel == 3'd2) && !w_busy && (|r_wstrb);
  assign w_tx_ovr   = w_wr_exec && (r_aw_sel == 3'd2) && w_busy;
  assign w_done_clr = (w_rd_hs && ARADDR[4:2] == 3'd3) ||
                      (w_wr_exec && r_aw_sel == 3'd1 && r_wstrb[0] && r_wdata[1]);
  assign w_ovr_clr  = w_wr_exec && r_aw_sel == 3'd1 && r_wstrb[0] && r_wdata[2];
  assign w_wr_resp  = (r_aw_sel > 3'd4 || w_tx_ovr) ? 2'b10 : 2'b00;

  // MSB-first words are left-aligned so the head bit is always at the top
  assign w_tx_al    = r_ctrl[2] ? w_tx_merge : w_tx_merge << (MAX_BITS-1-int'(r_ctrl[13:8]));
  assign w_tx_al_sh = r_ctrl[2] ? w_tx_al >> 1 : w_tx_al << 1;
  assign w_first    = r_ctrl[2] ? w_tx_al[0] : w_tx_al[MAX_BITS-1];
  assign w_head     = r_lsb ? r_tx_sh[0] : r_tx_sh[MAX_BITS-1];
  assign w_sh_next  = r_lsb ? r_tx_sh >> 1 : r_tx_sh << 1;
  assign w_rx_next  = r_lsb ? (r_rx_sh >> 1) | (MAX_BITS'(MISO) << (MAX_BITS-1))
                            : (r_rx_sh << 1) | MAX_BITS'(MISO);

  assign w_tick      = (r_cnt == r_div);
  assign w_last_edge = (r_edge == {r_len_m1, 1'b1});
  assign w_xfer_end  = (r_state == S_TRAIL) && w_tick;
  // even edges are leading; CPHA selects which edge samples
  assign w_do_sample = r_cpha ? r_edge[0] : ~r_edge[0];

  assign w_unused = ^{AWADDR, ARADDR, w_ctrl_m, w_tx_m32, w_ss_m32};

  always_comb begin
    w_ctrl_new         = '0;
    w_ctrl_new[2:0]    = w_ctrl_m[2:0];
    w_ctrl_new[13:8]   = (w_ctrl_m[13:8] >= 6'(MAX_BITS)) ? 6'(MAX_BITS-1) : w_ctrl_m[13:8];
    w_ctrl_new[16 +: DIV_W] = w_ctrl_m[16 +: DIV_W];
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = 2'b00;
    case (ARADDR[4:2])
      3'd0:    w_rd_data = r_ctrl;
      3'd1:    w_rd_data = {29'd0, r_ovr, r_done, w_busy};
      3'd2:    w_rd_data = '0;
      3'd3:    w_rd_data = 32'(r_rxdata);
      3'd4:    w_rd_data = 32'(r_ssmask);
      default: w_rd_resp = 2'b10;
    endcase
  end

  assign AWREADY = ~ARESET & ~r_aw_full & ~r_bvalid;
  assign WREADY  = ~ARESET & ~r_w_full & ~r_bvalid;
  assign ARREADY = ~ARESET & ~r_rvalid;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign RVALID  = r_rvalid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;
  assign SCLK    = r_sclk;
  assign MOSI    = r_mosi;
  assign SS      = r_ss;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_aw_full <= 1'b0; r_w_full <= 1'b0; r_aw_sel <= '0;
      r_wdata <= '0; r_wstrb <= '0;
      r_bvalid <= 1'b0; r_bresp <= '0;
      r_rvalid <= 1'b0; r_rresp <= '0; r_rdata <= '0;
      r_ctrl <= '0; r_ssmask <= NUM_SS'(1); r_txdata <= '0; r_rxdata <= '0;
      r_done <= 1'b0; r_ovr <= 1'b0;
    end else begin
      if (AWVALID && AWREADY) begin r_aw_full <= 1'b1; r_aw_sel <= AWADDR[4:2]; end
      if (WVALID && WREADY) begin r_w_full <= 1'b1; r_wdata <= WDATA; r_wstrb <= WSTRB; end
      if (r_bvalid && BREADY) r_bvalid <= 1'b0;
      if (w_wr_exec) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_resp;
        case (r_aw_sel)
          3'd0:    r_ctrl <= w_ctrl_new;
          3'd2:    if (!w_busy) r_txdata <= w_tx_merge;
          3'd4:    r_ssmask <= w_ss_m32[NUM_SS-1:0];
          default: ;
        endcase
      end
      if (r_rvalid && RREADY) r_rvalid <= 1'b0;
      if (w_rd_hs) begin r_rvalid <= 1'b1; r_rdata <= w_rd_data; r_rresp <= w_rd_resp; end
      // setting wins over a same-cycle clear
      if (w_xfer_end)      r_done <= 1'b1;
      else if (w_done_clr) r_done <= 1'b0;
      if (w_tx_ovr)        r_ovr <= 1'b1;
      else if (w_ovr_clr)  r_ovr <= 1'b0;
      if (w_xfer_end)
        r_rxdata <= r_lsb ? (r_rx_sh >> (MAX_BITS-1-int'(r_len_m1))) : r_rx_sh;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_tx_start) w_next = S_LEAD;
      S_LEAD:  if (w_tick) w_next = S_SHIFT;
      S_SHIFT: if (w_tick && w_last_edge) w_next = S_TRAIL;
      S_TRAIL: if (w_tick) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_sclk <= 1'b0; r_mosi <= 1'b0; r_ss <= '1;
      r_cnt <= '0; r_edge <= '0; r_tx_sh <= '0; r_rx_sh <= '0;
      r_cpha <= 1'b0; r_lsb <= 1'b0; r_len_m1 <= '0; r_div <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sclk <= r_ctrl[0];
          r_ss   <= '1;
          r_cnt  <= '0;
          r_edge <= '0;
          if (w_tx_start) begin
            r_cpha   <= r_ctrl[1];
            r_lsb    <= r_ctrl[2];
            r_len_m1 <= r_ctrl[13:8];
            r_div    <= r_ctrl[16 +: DIV_W];
            r_ss     <= ~r_ssmask;
            r_rx_sh  <= '0;
            r_tx_sh  <= r_ctrl[1] ? w_tx_al : w_tx_al_sh;
            if (!r_ctrl[1]) r_mosi <= w_first;
          end
        end
        S_LEAD: r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
        S_SHIFT: begin
          r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
          if (w_tick) begin
            r_sclk <= ~r_sclk;
            r_edge <= r_edge + 7'd1;
            if (w_do_sample) r_rx_sh <= w_rx_next;
            else begin
              r_mosi  <= w_head;
              r_tx_sh <= w_sh_next;
            end
          end
        end
        S_TRAIL: begin
          r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
          if (w_tick) r_ss <= '1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_spi_master.sv
// Directed bench for axil_spi_master: register access, SPI modes, overrun,
// handshake ordering/backpressure, unmapped access and mid-transfer reset.
module tb_axil_spi_master;
  logic        ACLK = 0, ARESET;
  logic [7:0]  AWADDR, ARADDR;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic        SCLK, MOSI, MISO;
  logic [7:0]  SS;

  int checks = 0, failures = 0;
  logic        loopback;
  logic [31:0] miso_pat;
  assign MISO = loopback ? MOSI : miso_pat[31];

  axil_spi_master dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS(SS)
  );

  always #5 ACLK = ~ACLK;

  // SPI-side monitor, sampled on the falling ACLK edge
  int cyc = 0, rises, per_bad, ss_low, ss_bad, last_rise, exp_per, b_cnt = 0;
  logic [7:0]  exp_ss;
  logic [31:0] mosi_w, miso_w, mosi_sr;
  logic        prev_sclk = 0;
  always @(negedge ACLK) begin
    cyc++;
    if (BVALID && BREADY) b_cnt++;
    if (SS != 8'hFF) begin
      ss_low++;
      if (SS !== exp_ss) ss_bad++;
    end
    if (SCLK === 1'b1 && prev_sclk === 1'b0) begin
      if (rises > 0 && (cyc - last_rise) != exp_per) per_bad++;
      if (rises < 32) begin
        mosi_w[rises] = MOSI;
        miso_w[rises] = MISO;
      end
      mosi_sr = {mosi_sr[30:0], MOSI};
      last_rise = cyc;
      rises++;
    end
    if (SCLK === 1'b0 && prev_sclk === 1'b1)
      miso_pat = {miso_pat[30:0], miso_pat[31]};
    prev_sclk = SCLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon(input int per, input logic [7:0] ss);
    rises = 0; per_bad = 0; ss_low = 0; ss_bad = 0; last_rise = 0;
    mosi_w = '0; miso_w = '0; mosi_sr = '0;
    exp_per = per; exp_ss = ss;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic axi_wr(input string tag, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int awd, input int wd, input int bwait,
                        input logic [1:0] exp_resp);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int n = 0;
    AWADDR = a; WDATA = d; WSTRB = s;
    while (!(aw_done && w_done) && n < 30) begin
      if (n >= awd && !aw_done) AWVALID = 1;
      if (n >= wd && !w_done) WVALID = 1;
      hs_aw = AWVALID && AWREADY;
      hs_w  = WVALID && WREADY;
      tick(1);
      if (hs_aw) begin aw_done = 1; AWVALID = 0; end
      if (hs_w)  begin w_done = 1;  WVALID = 0;  end
      n++;
    end
    AWVALID = 0; WVALID = 0;
    chk({tag, "_hs"}, {31'd0, aw_done && w_done}, 32'd1);
    n = 0;
    while (!BVALID && n < 30) begin tick(1); n++; end
    chk({tag, "_bvalid"}, {31'd0, BVALID}, 32'd1);
    for (int k = 0; k < bwait; k++) begin
      chk({tag, "_bhold"}, {29'd0, BVALID, AWREADY, WREADY}, 32'h4);
      tick(1);
    end
    chk({tag, "_bresp"}, {30'd0, BRESP}, {30'd0, exp_resp});
    BREADY = 1;
    tick(1);
    BREADY = 0;
  endtask

  task automatic axi_rd(input string tag, input logic [7:0] a, input logic [31:0] exp_d,
                        input logic [1:0] exp_resp, input int rwait);
    bit hs;
    int n = 0;
    ARADDR = a; ARVALID = 1;
    do begin
      hs = ARREADY;
      tick(1);
      n++;
    end while (!hs && n < 30);
    ARVALID = 0;
    n = 0;
    while (!RVALID && n < 30) begin tick(1); n++; end
    chk({tag, "_rvalid"}, {31'd0, RVALID}, 32'd1);
    for (int k = 0; k < rwait; k++) begin
      chk({tag, "_rhold"}, RDATA, exp_d);
      tick(1);
    end
    chk({tag, "_rdata"}, RDATA, exp_d);
    chk({tag, "_rresp"}, {30'd0, RRESP}, {30'd0, exp_resp});
    RREADY = 1;
    tick(1);
    RREADY = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (SS != 8'hFF && n < 2000) begin tick(1); n++; end
    chk({tag, "_done_timeout"}, {31'd0, SS == 8'hFF}, 32'd1);
    tick(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1; AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0;
    BREADY = 0; ARADDR = 0; ARVALID = 0; RREADY = 0;
    loopback = 0; miso_pat = 32'hC3A5_1E69;
    clear_mon(2, 8'hFF);
    tick(3);
    chk("rst_valid_ready", {27'd0, AWREADY, WREADY, ARREADY, BVALID, RVALID}, 32'd0);
    chk("rst_spi", {22'd0, SS, SCLK, MOSI}, {22'd0, 8'hFF, 2'b00});
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_resp", {28'd0, BRESP, RRESP}, 32'd0);
    ARESET = 0;
    #1;
    chk("post_rst_ready", {29'd0, AWREADY, WREADY, ARREADY}, 32'h7);
    tick(1);
    axi_rd("rst_ctrl",   8'h00, 32'h0, 2'b00, 0);
    axi_rd("rst_status", 8'h04, 32'h0, 2'b00, 0);
    axi_rd("rst_rxdata", 8'h0C, 32'h0, 2'b00, 0);
    axi_rd("rst_ssmask", 8'h10, 32'h1, 2'b00, 0);

    // mode 0, 8 bits, DIV 1, loopback
    axi_wr("m0_ctrl", 8'h00, 32'h0001_0700, 4'hF, 0, 0, 0, 2'b00);
    axi_wr("m0_ss",   8'h10, 32'h0000_0001, 4'hF, 0, 0, 0, 2'b00);
    loopback = 1;
    clear_mon(4, 8'hFE);
    axi_wr("m0_tx", 8'h08, 32'h0000_00A5, 4'hF, 0, 0, 0, 2'b00);
    wait_idle("m0");
    chk("m0_rises", rises, 8);
    chk("m0_period", per_bad, 0);
    chk("m0_mosi", {24'd0, mosi_sr[7:0]}, 32'hA5);
    chk("m0_ss_cycles", ss_low, 36);
    chk("m0_ss_value", ss_bad, 0);
    axi_rd("m0_status", 8'h04, 32'h2, 2'b00, 0);
    axi_rd("m0_rx", 8'h0C, 32'h0000_00A5, 2'b00, 3);
    axi_rd("m0_status_clr", 8'h04, 32'h0, 2'b00, 0);
    loopback = 0;

    // LEN saturates at MAX_BITS-1
    axi_wr("sat_ctrl", 8'h00, 32'h0000_3F00, 4'hF, 0, 0, 0, 2'b00);
    axi_rd("sat_rd", 8'h00, 32'h0000_1F00, 2'b00, 0);

    // mode 3, LSB first, 32 bits, DIV 0
    axi_wr("m3_ctrl", 8'h00, 32'h0000_1F07, 4'hF, 0, 0, 0, 2'b00);
    axi_wr("m3_ss",   8'h10, 32'h0000_0080, 4'hF, 0, 0, 0, 2'b00);
    tick(2);
    chk("m3_sclk_idle", {31'd0, SCLK}, 32'd1);
    clear_mon(2, 8'h7F);
    axi_wr("m3_tx", 8'h08, 32'hAAAA_AAAA, 4'hF, 0, 0, 0, 2'b00);
    wait_idle("m3");
    chk("m3_rises", rises, 32);
    chk("m3_period", per_bad, 0);
    chk("m3_mosi", mosi_w, 32'hAAAA_AAAA);
    chk("m3_ss_cycles", ss_low, 66);
    chk("m3_ss_value", ss_bad, 0);
    chk("m3_sclk_end", {31'd0, SCLK}, 32'd1);
    axi_rd("m3_status", 8'h04, 32'h2, 2'b00, 0);
    axi_wr("m3_w1c", 8'h04, 32'h0000_0002, 4'hF, 0, 0, 0, 2'b00);
    axi_rd("m3_status_clr", 8'h04, 32'h0, 2'b00, 0);
    axi_rd("m3_rx", 8'h0C, miso_w, 2'b00, 0);

    // overrun during a mode-0 transfer, DIV 3
    loopback = 1;
    axi_wr("ov_ctrl", 8'h00, 32'h0003_0700, 4'hF, 0, 0, 0, 2'b00);
    axi_wr("ov_ss",   8'h10, 32'h0000_0001, 4'hF, 0, 0, 0, 2'b00);
    clear_mon(8, 8'hFE);
    axi_wr("ov_tx",  8'h08, 32'h0000_003C, 4'hF, 0, 0, 0, 2'b00);
    axi_wr("ov_tx2", 8'h08, 32'h0000_00FF, 4'hF, 0, 0, 0, 2'b10);
    axi_rd("ov_status_busy", 8'h04, 32'h5, 2'b00, 0);
    wait_idle("ov");
    chk("ov_mosi", {24'd0, mosi_sr[7:0]}, 32'h3C);
    axi_rd("ov_status_done", 8'h04, 32'h6, 2'b00, 0);
    axi_rd("ov_rx", 8'h0C, 32'h0000_003C, 2'b00, 0);
    axi_wr("ov_w1c", 8'h04, 32'h0000_0004, 4'hF, 0, 0, 0, 2'b00);
    axi_rd("ov_status_clr", 8'h04, 32'h0, 2'b00, 0);
    loopback = 0;

    // TXDATA with no strobes does not start
    axi_wr("strb0_tx", 8'h08, 32'h0000_00FF, 4'h0, 0, 0, 0, 2'b00);
    tick(6);
    chk("strb0_ss", {24'd0, SS}, 32'hFF);
    axi_rd("strb0_status", 8'h04, 32'h0, 2'b00, 0);

    // byte strobes on CTRL
    axi_wr("strb_ctrl", 8'h00, 32'hFFFF_FF05, 4'h1, 0, 0, 0, 2'b00);
    axi_rd("strb_ctrl_rd", 8'h00, 32'h0003_0705, 2'b00, 0);

    // handshake ordering and B backpressure
    begin
      int b0;
      b0 = b_cnt;
      axi_wr("ord_aw_first", 8'h10, 32'h03, 4'hF, 0, 2, 0, 2'b00);
      chk("ord_aw_first_b", b_cnt - b0, 1);
      b0 = b_cnt;
      axi_wr("ord_w_first", 8'h10, 32'h05, 4'hF, 3, 0, 0, 2'b00);
      chk("ord_w_first_b", b_cnt - b0, 1);
      b0 = b_cnt;
      axi_wr("ord_both", 8'h10, 32'h09, 4'hF, 0, 0, 3, 2'b00);
      chk("ord_both_b", b_cnt - b0, 1);
    end
    axi_rd("ord_ssmask", 8'h10, 32'h09, 2'b00, 2);

    // unmapped offsets
    axi_rd("unm_rd", 8'h1C, 32'h0, 2'b10, 0);
    axi_wr("unm_wr", 8'h18, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 2'b10);
    axi_rd("unm_ctrl", 8'h00, 32'h0003_0705, 2'b00, 0);
    axi_rd("unm_ss",   8'h10, 32'h09, 2'b00, 0);

    // reset in the middle of a mode-3 transfer
    axi_wr("rs_ctrl", 8'h00, 32'h0003_1F07, 4'hF, 0, 0, 0, 2'b00);
    axi_wr("rs_ss",   8'h10, 32'h01, 4'hF, 0, 0, 0, 2'b00);
    axi_wr("rs_tx",   8'h08, 32'h1234_5678, 4'hF, 0, 0, 0, 2'b00);
    tick(10);
    chk("rs_active", {24'd0, SS}, 32'hFE);
    ARESET = 1;
    tick(1);
    chk("rs_spi", {23'd0, SS, SCLK}, {23'd0, 8'hFF, 1'b0});
    ARESET = 0;
    tick(1);
    axi_rd("rs_status", 8'h04, 32'h0, 2'b00, 0);
    axi_rd("rs_ctrl_rd", 8'h00, 32'h0, 2'b00, 0);
    axi_rd("rs_ssmask", 8'h10, 32'h1, 2'b00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
